reg_share_arbiter: RTL and testbench
====================================

// Module: reg_share_arbiter
// PURPOSE
//  Shares one 8-bit register (d/q, async active-low reset) among N_REQ requesters.
//  Round-robin arbitration and per-requester req/ack handshake.
//  Each granted transaction is one read or one write.
//  Sits beside the register: drives its d input, observes its q output.
//  Counts committed writes for status/debug.
// PARAMETERS
//  N_REQ  4   number of requesters (2..16)
//  DW     8   register data width
//  CW     16  width of write counter (saturating)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active-low
//  req        in   N_REQ     per-requester access request, held until ack
//  wr         in   N_REQ     1=write, 0=read; valid while req high
//  wdata      in   N_REQ*DW  write data, requester i at [i*DW +: DW]
//  gnt        out  N_REQ     one-hot grant, registered
//  ack        out  N_REQ     one-cycle completion pulse, registered
//  rdata      out  DW        read data, valid in ack cycle, held until next read
//  reg_q      in   DW        shared register output
//  reg_d      out  DW        shared register input (combinational)
//  wr_cnt     out  CW        committed write count, saturates at all-ones
//  lock       in   N_REQ     only present with REG_ARB_LOCK_EN
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, ack=0, rdata=0, wr_cnt=0, rr pointer=0.
//  Reset is async assert, sync deassert at the block boundary.
//  reg_d mux:
//   - reg_d = wdata[g] only in GRANT with wr[g]=1;
//   - reg_d = reg_q otherwise, including during reset.
//  FSM:
//   - IDLE: if any eligible req, register winner -> GRANT, gnt[winner]=1; else stay.
//   - GRANT: one cycle. Write: reg_d=wdata[g]; register captures at end of cycle.
//     Read: rdata<=reg_q at end of cycle. Always -> DONE, ack[g]<=1.
//   - DONE: one cycle. ack[g]=1, gnt[g] stays 1.
//     Arbitrate the others: winner -> GRANT (back-to-back), none -> IDLE.
//  Eligible: req[i]=1, excluding the current grantee while in DONE.
//   - The requester drops req on the edge that ends its ack cycle.
//  Arbitration:
//   - Round robin starting at pointer p; first i in p, p+1, ... (mod N_REQ) with eligible req wins.
//   - On grant to i, p <= (i+1) mod N_REQ.
//  Latency:
//   - req seen in IDLE at cycle 0: gnt cycles 1-2, ack cycle 2.
//   - Write value visible on reg_q in cycle 2.
//   - Sustained throughput: one access per 2 cycles.
//  wr_cnt: +1 at the end of each GRANT cycle with wr[g]=1; holds at 2^CW-1.
//  Simultaneous requests: exactly one gnt bit is ever high; the others wait.
//  Request withdrawn before grant: ignored, no ack.
//  Request withdrawn during GRANT/DONE: the access still completes and ack still pulses.
//  Reset mid-transaction: the transaction is aborted, no ack is issued,
//  and the register value is whatever the register's own reset gives.
// CONFIGURATION
//  REG_ARB_LOCK_EN defined:
//   - Adds input lock[N_REQ].
//   - If lock[g]=1 and req[g]=1 in DONE: next state is GRANT for the same g, with no arbitration.
//   - p is not advanced; other requesters are starved while lock is held.
//   - lock is ignored in IDLE.
//  REG_ARB_LOCK_EN undefined:
//   - No lock port.
//   - Strict round robin; a requester never gets two consecutive grants while others request.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT of a write to 0xA5 -> gnt=0, ack=0, wr_cnt=0,
//    no further ack after release.
//  2 Single write/read: req0 wr=1 wdata=0x3C at cyc0 -> gnt[0] cyc1-2, ack[0] cyc2,
//    reg_q=0x3C cyc2, wr_cnt=1. Then read -> rdata=0x3C in ack cycle.
//  3 Fairness: req[3:0]=1111 held, each re-requests after ack
//    -> grant order 0,1,2,3,0 with no idle cycles between.
//  4 Contention: req1 and req2 raised in the same cycle, p=2 -> req2 acked first,
//    req1 acked 2 cycles later, and reg_q ends with req1's data.
//  5 Saturation: CW=4, 20 writes -> wr_cnt stops at 0xF.
//  6 REG_ARB_LOCK_EN: req0 with lock=1 for 3 writes while req1 pending
//    -> ack[0] x3 back-to-back, then req1 granted.
//    Without the macro -> alternates 0,1,0.

Source files
------------

// File: rtl/reg_share_arbiter_if.sv
// rtl/reg_share_arbiter_if.sv - requester/register bus shared by reg_share_arbiter and its environment
// The lock vector only exists when REG_ARB_LOCK_EN is defined.
interface reg_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int CW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    wr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic [DW-1:0]       reg_q;
  logic [DW-1:0]       reg_d;
  logic [CW-1:0]       wr_cnt;
`ifdef REG_ARB_LOCK_EN
  logic [N_REQ-1:0]    lock;

  modport slave (
    input  req, wr, wdata, reg_q, lock,
    output gnt, ack, rdata, reg_d, wr_cnt
  );
  modport master (
    output req, wr, wdata, reg_q, lock,
    input  gnt, ack, rdata, reg_d, wr_cnt
  );
`else
  modport slave (
    input  req, wr, wdata, reg_q,
    output gnt, ack, rdata, reg_d, wr_cnt
  );
  modport master (
    output req, wr, wdata, reg_q,
    input  gnt, ack, rdata, reg_d, wr_cnt
  );
`endif
endinterface

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin req/ack arbiter sharing one register among N_REQ requesters
// REG_ARB_LOCK_EN adds a per-requester lock that re-grants the current owner without arbitration.
module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_share_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_int_n;

  logic [N_REQ-1:0] elig;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [SW-1:0]    scan;
  logic [SW-1:0]    nxt;
  logic [DW-1:0]    wdata_g;
  logic             wr_g;
  logic             lock_hold;
  logic [DW-1:0]    reg_d_c;

  // Reset asserts immediately but releases only on a clock edge.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  assign wdata_g = bus.wdata[int'(owner_q)*DW +: DW];
  assign wr_g    = bus.wr[owner_q];

`ifdef REG_ARB_LOCK_EN
  assign lock_hold = bus.lock[owner_q] & bus.req[owner_q];
`else
  assign lock_hold = 1'b0;
`endif

  // Scan downwards so the lowest offset from the pointer is the last (winning) hit.
  always_comb begin
    elig = bus.req;
    if (state_q == DONE) elig[owner_q] = 1'b0;
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + SW'(k);
      if (scan >= SW'(N_REQ)) scan = scan - SW'(N_REQ);
      if (elig[scan[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[PW-1:0];
      end
    end
    nxt = {1'b0, win_idx} + SW'(1);
    if (nxt == SW'(N_REQ)) nxt = '0;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    wr_cnt_d = wr_cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    reg_d_c  = bus.reg_q;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          ptr_d   = nxt[PW-1:0];
        end
      end

      GRANT: begin
        if (wr_g) begin
          reg_d_c = wdata_g;
          if (wr_cnt_q != {CW{1'b1}}) wr_cnt_d = wr_cnt_q + CW'(1);
        end else begin
          rdata_d = bus.reg_q;
        end
        ack_d   = gnt_q;
        state_d = DONE;
      end

      DONE: begin
        if (lock_hold) begin
          state_d = GRANT;
        end else if (win_vld) begin
          state_d = GRANT;
          owner_d = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          ptr_d   = nxt[PW-1:0];
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      wr_cnt_q <= wr_cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.wr_cnt = wr_cnt_q;
  assign bus.reg_d  = reg_d_c;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - randomized and directed bench for reg_share_arbiter against a transaction model
// Build with REG_ARB_LOCK_EN defined to exercise the lock option.
module tb_reg_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.N_REQ(N), .DW(DW), .CW(CW)) bus ();

  reg_share_arbiter #(.N_REQ(N), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [N-1:0]    req_r = '0;
  logic [N-1:0]    wr_r = '0;
  logic [N*DW-1:0] wdata_r = '0;
  logic [N-1:0]    lock_r = '0;
  logic [DW-1:0]   reg_r;

  assign bus.req   = req_r;
  assign bus.wr    = wr_r;
  assign bus.wdata = wdata_r;
  assign bus.reg_q = reg_r;
`ifdef REG_ARB_LOCK_EN
  assign bus.lock  = lock_r;
`endif

  // The shared register itself, reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_r <= '0;
    else        reg_r <= bus.reg_d;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Job word: [7:0] data, [8] write, [9] withdraw after one cycle, [15:12] idle cycles before raising.
  int jobs [N][$];
  bit mon_en = 1'b0;

  function automatic int mk_job(bit w, logic [7:0] d, int gap, bit oneshot);
    return (gap << 12) | (int'(oneshot) << 9) | (int'(w) << 8) | int'(d);
  endfunction

  // Requester agents: hold req until ack, chain the next job without a gap when available.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          req_r[i] = 1'b0;
        end else if (req_r[i]) begin
          if (bus.ack[i] || jobs[i].size() == 0 || jobs[i][0][9]) begin
            if (jobs[i].size() > 0) void'(jobs[i].pop_front());
            req_r[i] = 1'b0;
            if (bus.ack[i] && jobs[i].size() > 0 && jobs[i][0][15:12] == 0) begin
              wr_r[i] = jobs[i][0][8];
              wdata_r[i*DW +: DW] = jobs[i][0][7:0];
              req_r[i] = 1'b1;
            end
          end
        end else if (jobs[i].size() > 0) begin
          if (jobs[i][0][15:12] == 0) begin
            wr_r[i] = jobs[i][0][8];
            wdata_r[i*DW +: DW] = jobs[i][0][7:0];
            req_r[i] = 1'b1;
          end else begin
            jobs[i][0] = jobs[i][0] - 4096;
          end
        end
      end
    end
  end

  // Transaction model: phase 0 idle, 1 access, 2 completion.
  int m_phase, m_g, m_p, m_cnt;
  logic [DW-1:0] m_reg, m_rdata;
  int glog[$];

  initial begin
    logic [N-1:0]    er, ew, el, cand, eg, ea;
    logic [N*DW-1:0] ewd;
    logic [DW-1:0]   ed;
    int win;
    bit hold;
    forever begin
      @(posedge clk);
      er = req_r; ew = wr_r; ewd = wdata_r; el = lock_r;
      #1;
      if (!mon_en) begin
        m_phase = 0; m_g = 0; m_p = 0; m_cnt = 0; m_reg = '0; m_rdata = '0;
      end else begin
        if (m_phase == 1) begin
          if (ew[m_g]) begin
            m_reg = ewd[m_g*DW +: DW];
            if (m_cnt < CNT_MAX) m_cnt++;
          end else begin
            m_rdata = m_reg;
          end
          m_phase = 2;
        end else begin
          hold = 1'b0;
`ifdef REG_ARB_LOCK_EN
          if (m_phase == 2 && el[m_g] && er[m_g]) hold = 1'b1;
`endif
          if (hold) begin
            m_phase = 1;
          end else begin
            cand = er;
            if (m_phase == 2) cand[m_g] = 1'b0;
            win = -1;
            for (int k = 0; k < N; k++)
              if (win < 0 && cand[(m_p + k) % N]) win = (m_p + k) % N;
            if (win >= 0) begin
              m_g = win;
              m_p = (win + 1) % N;
              m_phase = 1;
            end else begin
              m_phase = 0;
            end
          end
        end
        eg = '0; ea = '0;
        if (m_phase != 0) eg[m_g] = 1'b1;
        if (m_phase == 2) ea[m_g] = 1'b1;
        ed = (m_phase == 1 && wr_r[m_g]) ? wdata_r[m_g*DW +: DW] : m_reg;
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("ack", 32'(bus.ack), 32'(ea));
        check("rdata", 32'(bus.rdata), 32'(m_rdata));
        check("wr_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
        check("reg_q", 32'(bus.reg_q), 32'(m_reg));
        check("reg_d", 32'(bus.reg_d), 32'(ed));
        if (bus.gnt != 0 && bus.ack == 0)
          for (int i = 0; i < N; i++) if (bus.gnt[i]) glog.push_back(i);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < N; i++) jobs[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    glog.delete();
  endtask

  task automatic wait_idle(input string tag, input bit rand_lock);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (rand_lock) lock_r = N'($urandom);
      done = (req_r == 0) && (m_phase == 0);
      for (int i = 0; i < N; i++) if (jobs[i].size() != 0) done = 1'b0;
    end
    lock_r = '0;
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    check({tag, "_len"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(glog[i]), 32'(exp[i]));
  endtask

  initial begin
    bit seen;
    int exp_q[$];

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
    check("rst_reg_d", 32'(bus.reg_d), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Reset in the middle of a write access.
    jobs[0].push_back(mk_job(1'b1, 8'hA5, 0, 1'b0));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.gnt[0] && !bus.ack[0];
    end
    if (!seen) check("t1_grant_timeout", 32'd1, 32'd0);
    rst_n = 1'b0;
    mon_en = 1'b0;
    jobs[0].delete();
    #1;
    check("t1_gnt", 32'(bus.gnt), 32'd0);
    check("t1_ack", 32'(bus.ack), 32'd0);
    check("t1_wr_cnt", 32'(bus.wr_cnt), 32'd0);
    check("t1_reg_q", 32'(bus.reg_q), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t1_no_ack", 32'(bus.ack), 32'd0);
    end
    mon_en = 1'b1;
    glog.delete();

    // Single write then read back.
    jobs[0].push_back(mk_job(1'b1, 8'h3C, 0, 1'b0));
    jobs[0].push_back(mk_job(1'b0, 8'h00, 0, 1'b0));
    wait_idle("t2", 1'b0);
    check("t2_reg_q", 32'(bus.reg_q), 32'h3C);
    check("t2_rdata", 32'(bus.rdata), 32'h3C);
    check("t2_wr_cnt", 32'(bus.wr_cnt), 32'd1);
    exp_q = '{0, 0};
    check_order("t2_order", exp_q);

    // Fairness with all four requesting continuously.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        jobs[i].push_back(mk_job(1'b1, 8'(16 * i + r), 0, 1'b0));
    wait_idle("t3", 1'b0);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("t3_order", exp_q);

    // Contention with the pointer at 2.
    do_reset();
    jobs[1].push_back(mk_job(1'b0, 8'h00, 0, 1'b0));
    wait_idle("t4a", 1'b0);
    glog.delete();
    jobs[1].push_back(mk_job(1'b1, 8'h11, 0, 1'b0));
    jobs[2].push_back(mk_job(1'b1, 8'h22, 0, 1'b0));
    wait_idle("t4", 1'b0);
    exp_q = '{2, 1};
    check_order("t4_order", exp_q);
    check("t4_reg_q", 32'(bus.reg_q), 32'h11);

    // Write counter saturation.
    do_reset();
    for (int k = 0; k < 20; k++)
      jobs[$urandom_range(N - 1)].push_back(mk_job(1'b1, 8'($urandom), $urandom_range(2), 1'b0));
    wait_idle("t5", 1'b0);
    check("t5_wr_cnt", 32'(bus.wr_cnt), 32'(CNT_MAX));

    // Lock held by requester 0 while requester 1 waits.
    do_reset();
    lock_r = 4'b0001;
    for (int k = 0; k < 3; k++) jobs[0].push_back(mk_job(1'b1, 8'(k + 1), 0, 1'b0));
    jobs[1].push_back(mk_job(1'b1, 8'h77, 0, 1'b0));
    wait_idle("t6", 1'b0);
`ifdef REG_ARB_LOCK_EN
    exp_q = '{0, 0, 0, 1};
`else
    exp_q = '{0, 1, 0, 0};
`endif
    check_order("t6_order", exp_q);

    // Random traffic including withdrawn requests.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 30; k++)
        jobs[i].push_back(mk_job(1'($urandom), 8'($urandom), $urandom_range(3),
                                 ($urandom_range(7) == 0)));
    wait_idle("rand", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
